// File: rtl/oq_rate_limiter.sv
// -----------------------------------------------------------------------------
// oq_rate_limiter
//
// Per-port token-bucket shaper that sits between one output-queue port and
// the MAC/CPU tx queue. Words are buffered in a small FIFO. A packet is only
// released once the bucket holds enough byte credits for its length. The
// length is taken from the IO-queue module header, if the packet has one.
// Packets are released whole and are never split.
//
// Optional feature (macro OQ_RATE_LIMITER_STATS_EN):
//   defined   -> stat_pkts_delayed / stat_stall_cycles count packets that had
//                to wait for tokens and cycles spent waiting.
//   undefined -> no counter logic; both stat ports read 0.
//   Shaping behaviour is the same in both builds.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   in_data/in_ctrl    word from the output queue, written when in_wr=1
//   in_rdy             high while the FIFO has more than 2 free entries
//   out_data/out_ctrl  registered word to the tx queue, valid when out_wr=1
//   out_rdy            downstream can take a word this cycle
//   rate_limit_en      0 = transparent pass-through (bucket held full)
//   token_inc          bytes added to the bucket every refill
//   token_interval     cycles between refills (0 behaves as 1)
//   token_max          bucket depth in bytes
//   tokens             current bucket level
//   stat_*             32-bit wrapping statistics
// -----------------------------------------------------------------------------
module oq_rate_limiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int TOKEN_WIDTH     = 20,
  parameter int INTERVAL_WIDTH  = 16,
  parameter int FIFO_DEPTH_BITS = 3,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL = 8'hFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [CTRL_WIDTH-1:0]     in_ctrl,
  input  logic                      in_wr,
  output logic                      in_rdy,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [CTRL_WIDTH-1:0]     out_ctrl,
  output logic                      out_wr,
  input  logic                      out_rdy,
  input  logic                      rate_limit_en,
  input  logic [TOKEN_WIDTH-1:0]    token_inc,
  input  logic [INTERVAL_WIDTH-1:0] token_interval,
  input  logic [TOKEN_WIDTH-1:0]    token_max,
  output logic [TOKEN_WIDTH-1:0]    tokens,
  output logic [31:0]               stat_pkts_delayed,
  output logic [31:0]               stat_stall_cycles
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
  localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;
  // One spare bit so that tokens + token_inc cannot overflow.
  localparam int TW1    = TOKEN_WIDTH + 1;

  localparam logic [FIFO_DEPTH_BITS:0] FULL_LEVEL = (FIFO_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_BITS:0] NF_LEVEL   = (FIFO_DEPTH_BITS + 1)'(DEPTH - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_SEND
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0]          mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   count;
  logic                       fifo_empty;
  logic                       wr_en;
  logic                       pop;
  logic [DATA_WIDTH-1:0]      head_data;
  logic [CTRL_WIDTH-1:0]      head_ctrl;

  assign fifo_empty = (count == '0);
  assign in_rdy     = (count < NF_LEVEL);
  // The upstream is expected to honour in_rdy. The full check only keeps the
  // pointers consistent if it does not.
  assign wr_en      = in_wr && (count != FULL_LEVEL);
  assign pop        = (state == S_SEND) && !fifo_empty && out_rdy;
  assign {head_ctrl, head_data} = mem[rd_ptr];

  // NOTE: the storage array has no reset. Only the pointers and the count
  // decide what is valid, and a reset term would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {in_ctrl, in_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Admission decision
  // ---------------------------------------------------------------------------
  logic [15:0]    pkt_len;
  logic [TW1-1:0] tokens_w;
  logic [TW1-1:0] max_w;
  logic [TW1-1:0] inc_w;
  logic [TW1-1:0] len_w;
  logic           go;
  logic           deduct;

  assign tokens_w = {1'b0, tokens};
  assign max_w    = {1'b0, token_max};
  assign inc_w    = {1'b0, token_inc};
  assign len_w    = TW1'(pkt_len);

  // A packet longer than the whole bucket can never meet tokens >= len. It
  // is let through once the bucket is full, so it cannot block the port.
  assign go     = !rate_limit_en || (tokens_w >= len_w) ||
                  ((len_w > max_w) && (tokens == token_max));
  assign deduct = rate_limit_en && go && ((state == S_CHECK) || (state == S_WAIT));

  // ---------------------------------------------------------------------------
  // Bucket refill
  // ---------------------------------------------------------------------------
  logic [INTERVAL_WIDTH-1:0] int_cnt;
  logic                      wrap;
  logic                      tok_init;
  logic [TW1-1:0]            sum_w;
  logic [TOKEN_WIDTH-1:0]    capped;
  logic [TOKEN_WIDTH-1:0]    tokens_next;

  // ">=" (not "==") gives a prompt wrap if token_interval is lowered below
  // the current count.
  assign wrap = (token_interval == '0) || (int_cnt >= token_interval - 1'b1);

  // NOTE: purely combinational next-state logic uses blocking assignments and
  // gives every variable a value on every path, so no latch is inferred.
  always_comb begin
    sum_w       = tokens_w + (wrap ? inc_w : '0);
    // The min() against token_max also clamps the level when token_max is
    // lowered below the current level.
    capped      = (sum_w > max_w) ? token_max : TOKEN_WIDTH'(sum_w);
    tokens_next = capped;
    if (deduct) begin
      tokens_next = ({1'b0, capped} > len_w) ? TOKEN_WIDTH'({1'b0, capped} - len_w) : '0;
    end
    // The bucket starts full. It stays full while shaping is disabled.
    if (!tok_init || !rate_limit_en) begin
      tokens_next = token_max;
    end
  end

  // NOTE: all clocked state is updated with non-blocking assignments, so the
  // order of the statements inside a block does not matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_cnt  <= '0;
      tokens   <= '0;
      tok_init <= 1'b0;
    end else begin
      int_cnt  <= wrap ? '0 : int_cnt + 1'b1;
      tokens   <= tokens_next;
      tok_init <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet FSM with registered outputs
  // ---------------------------------------------------------------------------
  // seen_zero: a ctrl==0 word of the current packet has been sent. The first
  // later word with ctrl!=0 is the last word of the packet.
  logic seen_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pkt_len   <= '0;
      seen_zero <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      out_wr    <= 1'b0;
    end else begin
      out_wr <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // Look at the head word without popping it. It is sent in S_SEND.
          if (!fifo_empty) begin
            pkt_len <= (head_ctrl == IOQ_CTRL) ? head_data[15:0] : 16'd0;
            state   <= S_CHECK;
          end
        end
        S_CHECK, S_WAIT: begin
          if (go) begin
            seen_zero <= 1'b0;
            state     <= S_SEND;
          end else begin
            state <= S_WAIT;
          end
        end
        S_SEND: begin
          if (pop) begin
            out_data <= head_data;
            out_ctrl <= head_ctrl;
            out_wr   <= 1'b1;
            if (head_ctrl == '0) begin
              seen_zero <= 1'b1;
            end else if (seen_zero) begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef OQ_RATE_LIMITER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_pkts_delayed <= '0;
      stat_stall_cycles <= '0;
    end else begin
      // Count once, on the CHECK -> WAIT transition.
      if ((state == S_CHECK) && !go) stat_pkts_delayed <= stat_pkts_delayed + 1'b1;
      if (state == S_WAIT)           stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`else
  assign stat_pkts_delayed = '0;
  assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_oq_rate_limiter.sv
// -----------------------------------------------------------------------------
// tb_oq_rate_limiter
//
// Self-checking bench for oq_rate_limiter. Every word driven in is pushed to
// a scoreboard queue. Every out_wr word is popped and compared. Bucket levels
// and statistics are compared against values worked out from the
// token-bucket rules.
// -----------------------------------------------------------------------------
module tb_oq_rate_limiter;

`ifdef OQ_RATE_LIMITER_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        rate_limit_en;
  logic [19:0] token_inc;
  logic [15:0] token_interval;
  logic [19:0] token_max;
  logic [19:0] tokens;
  logic [31:0] stat_pkts_delayed;
  logic [31:0] stat_stall_cycles;

  oq_rate_limiter dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_ctrl           (in_ctrl),
    .in_wr             (in_wr),
    .in_rdy            (in_rdy),
    .out_data          (out_data),
    .out_ctrl          (out_ctrl),
    .out_wr            (out_wr),
    .out_rdy           (out_rdy),
    .rate_limit_en     (rate_limit_en),
    .token_inc         (token_inc),
    .token_interval    (token_interval),
    .token_max         (token_max),
    .tokens            (tokens),
    .stat_pkts_delayed (stat_pkts_delayed),
    .stat_stall_cycles (stat_stall_cycles)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          out_cnt  = 0;
  int          pkt_id   = 0;
  logic [71:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor and scoreboard. It samples 1 ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset && out_wr) begin
        // out_rdy still holds the value it had at this edge.
        check("wr_after_rdy0", 128'(out_rdy), 128'(1));
        out_cnt++;
        if (exp_q.size() == 0) check("sb_unexpected", 128'(1), 128'(0));
        else check("sb_word", 128'({out_ctrl, out_data}), 128'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic put_word(input logic [7:0] c, input logic [63:0] d);
    int budget = 1000;
    @(negedge clk);
    in_wr = 1'b0;
    while (!in_rdy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_rdy) begin
      check("in_rdy_timeout", 128'(0), 128'(1));
      return;
    end
    in_ctrl = c;
    in_data = d;
    in_wr   = 1'b1;
    exp_q.push_back({c, d});
  endtask

  function automatic logic [63:0] hdr_word(input int id, input logic [15:0] len);
    logic [15:0] id16 = id[15:0];
    return {id16, 32'hA5A5_0000, len};
  endfunction

  function automatic logic [63:0] dat_word(input int id, input int idx);
    logic [15:0] id16  = id[15:0];
    logic [15:0] idx16 = idx[15:0];
    return {id16, 16'hD00D, 16'h0000, idx16};
  endfunction

  // Header plus ndata words: ctrl 0 for all but the last, which has 8'h80.
  task automatic send_pkt(input logic [15:0] len, input int ndata);
    pkt_id++;
    put_word(8'hFF, hdr_word(pkt_id, len));
    for (int i = 0; i < ndata; i++) begin
      put_word((i == ndata - 1) ? 8'h80 : 8'h00, dat_word(pkt_id, i));
    end
    @(negedge clk);
    in_wr = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int budget = 2000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    check(tag, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int          base;
    int          drops;
    logic [19:0] prev;
    logic [31:0] s0;
    logic [31:0] s1;

    reset          = 1'b1;
    in_wr          = 1'b0;
    in_data        = '0;
    in_ctrl        = '0;
    out_rdy        = 1'b1;
    rate_limit_en  = 1'b0;
    token_inc      = '0;
    token_interval = 16'd1;
    token_max      = 20'd500;

    // Reset state
    #3;
    check("rst_out_wr",   128'(out_wr),            128'(0));
    check("rst_out_data", 128'(out_data),          128'(0));
    check("rst_out_ctrl", 128'(out_ctrl),          128'(0));
    check("rst_tokens",   128'(tokens),            128'(0));
    check("rst_in_rdy",   128'(in_rdy),            128'(1));
    check("rst_stat_d",   128'(stat_pkts_delayed), 128'(0));
    check("rst_stat_s",   128'(stat_stall_cycles), 128'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sample();
    check("tokens_init", 128'(tokens), 128'(500));

    // 1: pass-through, three 64B packets back to back
    base = out_cnt;
    send_pkt(16'd64, 8);
    send_pkt(16'd64, 8);
    send_pkt(16'd64, 8);
    wait_drain("t1_drain");
    check("t1_count",  128'(out_cnt - base), 128'(27));
    check("t1_tokens", 128'(tokens),         128'(500));

    // 2: token_max=100, inc=0. The first packet passes and the second waits.
    @(negedge clk);
    token_max     = 20'd100;
    rate_limit_en = 1'b1;
    sample();
    check("t2_clamp", 128'(tokens), 128'(100));
    send_pkt(16'd64, 8);
    wait_drain("t2_drain1");
    check("t2_tokens36", 128'(tokens),            128'(36));
    check("t2_delayed0", 128'(stat_pkts_delayed), 128'(0));
    pkt_id++;
    put_word(8'hFF, hdr_word(pkt_id, 16'd64));
    for (int i = 0; i < 5; i++) put_word(8'h00, dat_word(pkt_id, i));
    @(negedge clk);
    in_wr = 1'b0;
    repeat (4) sample();
    check("t2_in_rdy_low", 128'(in_rdy),            128'(0));
    check("t2_delayed1",   128'(stat_pkts_delayed), 128'(STATS_ON ? 1 : 0));
    check("t2_held36",     128'(tokens),            128'(36));
    s0 = stat_stall_cycles;
    repeat (10) sample();
    s1 = stat_stall_cycles;
    check("t2_stall_grow", 128'(s1 - s0), 128'(STATS_ON ? 10 : 0));
    check("t2_no_output",  128'(exp_q.size()), 128'(6));

    // 3: refill 8 every 4 cycles. Admitted at 68, leaving 4.
    @(negedge clk);
    token_inc      = 20'd8;
    token_interval = 16'd4;
    begin
      int budget = 200;
      do begin
        sample();
        budget--;
      end while (tokens >= 20'd36 && budget > 0);
    end
    check("t3_after_deduct", 128'(tokens), 128'(4));
    put_word(8'h00, dat_word(pkt_id, 5));
    put_word(8'h00, dat_word(pkt_id, 6));
    put_word(8'h80, dat_word(pkt_id, 7));
    @(negedge clk);
    in_wr = 1'b0;
    wait_drain("t3_drain");
    check("t3_delayed", 128'(stat_pkts_delayed), 128'(STATS_ON ? 1 : 0));

    // 4: len 1500 > token_max 1000, refill 100 every cycle
    @(negedge clk);
    reset          = 1'b1;
    #1;
    exp_q.delete();
    token_max      = 20'd1000;
    token_inc      = 20'd100;
    token_interval = 16'd1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sample();
    check("t4_tokens_init", 128'(tokens), 128'(1000));
    drops = 0;
    prev  = tokens;
    fork
      begin
        send_pkt(16'd1000, 2);
        send_pkt(16'd1500, 2);
      end
      begin
        int budget = 300;
        while (drops < 2 && budget > 0) begin
          sample();
          if (prev == 20'd1000 && tokens == 20'd0) drops++;
          prev = tokens;
          budget--;
        end
      end
    join
    check("t4_full_drops", 128'(drops), 128'(2));
    sample();
    check("t4_refill_on", 128'(tokens), 128'(100));
    wait_drain("t4_drain");

    // 5: out_rdy toggling during SEND
    @(negedge clk);
    rate_limit_en = 1'b0;
    base = out_cnt;
    fork
      begin
        send_pkt(16'd64, 8);
        send_pkt(16'd64, 8);
      end
      begin
        repeat (60) begin
          @(negedge clk);
          out_rdy = ~out_rdy;
        end
      end
    join
    @(negedge clk);
    out_rdy = 1'b1;
    wait_drain("t5_drain");
    check("t5_count",  128'(out_cnt - base), 128'(18));
    check("t5_tokens", 128'(tokens),         128'(1000));

    // 6: reset in the middle of SEND
    send_pkt(16'd64, 8);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_mid_send", 128'(exp_q.size() != 0), 128'(1));
    exp_q.delete();
    check("t6_out_wr",   128'(out_wr),   128'(0));
    check("t6_out_data", 128'(out_data), 128'(0));
    check("t6_out_ctrl", 128'(out_ctrl), 128'(0));
    check("t6_tokens",   128'(tokens),   128'(0));
    check("t6_in_rdy",   128'(in_rdy),   128'(1));
    repeat (2) @(negedge clk);
    rate_limit_en = 1'b1;
    token_max     = 20'd300;
    token_inc     = 20'd0;
    reset         = 1'b0;
    sample();
    check("t6_tokens_init", 128'(tokens), 128'(300));
    base = out_cnt;
    send_pkt(16'd64, 8);
    wait_drain("t6_drain");
    check("t6_count",   128'(out_cnt - base),    128'(9));
    check("t6_tokens2", 128'(tokens),            128'(236));
    check("t6_stat_d",  128'(stat_pkts_delayed), 128'(0));
    check("t6_stat_s",  128'(stat_stall_cycles), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
